// File: rtl/rtype_exec_unit.sv
// R-type execute stage: ALU/shift/HI-LO moves in one cycle, iterative MULTU into HI/LO (EXEC_OVF_TRAP_EN adds ADD/SUB overflow trap).
// Latency: single-cycle ops write the register bank the cycle after accept; MULTU holds for 32/MUL_BITS_PER_CYCLE cycles.
// Backpressure: in_ready is low for the whole MUL phase; an unaccepted instruction must be held by the issuer.
module rtype_exec_unit #(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        regWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    output logic        busy,
    output logic        illegal,
    output logic        ovf
);

    localparam logic [5:0] MUL_STEPS = 6'(32 / MUL_BITS_PER_CYCLE);

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    typedef enum logic [0:0] {IDLE, MUL} execState_e;

    execState_e state, nextState;

    logic [5:0]  opcode, funct;
    logic [4:0]  rd, shamt;
    logic [31:0] hiReg, loReg;
    logic [31:0] sum, diff, aluResult;
    logic        isLegal, isMult, signedOvf, accept, trap;
    logic [63:0] mulAcc, mulCand, mulAccNext, mulCandNext;
    logic [31:0] mulPlier, mulPlierNext;
    logic [5:0]  stepCnt;
    logic        unusedRegFields;

    assign opcode = inst[31:26];
    assign rd     = inst[15:11];
    assign shamt  = inst[10:6];
    assign funct  = inst[5:0];
    // Operand selection already happened in the register bank.
    assign unusedRegFields = ^inst[25:16];

    assign in_ready = (state == IDLE);
    assign busy     = (state == MUL);
    assign accept   = in_valid && in_ready;

    always_comb begin
        isLegal   = 1'b1;
        isMult    = 1'b0;
        signedOvf = 1'b0;
        aluResult = '0;
        sum       = rs_data + rt_data;
        diff      = rs_data - rt_data;
        case (funct)
            FN_ADD: begin
                aluResult = sum;
                signedOvf = (rs_data[31] == rt_data[31]) && (sum[31] != rs_data[31]);
            end
            FN_ADDU: aluResult = sum;
            FN_SUB: begin
                aluResult = diff;
                signedOvf = (rs_data[31] != rt_data[31]) && (diff[31] != rs_data[31]);
            end
            FN_SUBU:  aluResult = diff;
            FN_AND:   aluResult = rs_data & rt_data;
            FN_OR:    aluResult = rs_data | rt_data;
            FN_XOR:   aluResult = rs_data ^ rt_data;
            FN_NOR:   aluResult = ~(rs_data | rt_data);
            FN_SLT:   aluResult = {31'd0, $signed(rs_data) < $signed(rt_data)};
            FN_SLTU:  aluResult = {31'd0, rs_data < rt_data};
            FN_SLL:   aluResult = rt_data << shamt;
            FN_SRL:   aluResult = rt_data >> shamt;
            FN_SRA:   aluResult = $unsigned($signed(rt_data) >>> shamt);
            FN_MFHI:  aluResult = hiReg;
            FN_MFLO:  aluResult = loReg;
            FN_MULTU: isMult = 1'b1;
            default:  isLegal = 1'b0;
        endcase
        if (opcode != 6'd0) begin
            isLegal = 1'b0;
            isMult  = 1'b0;
        end
    end

    // Shift-add over MUL_BITS_PER_CYCLE multiplier bits per clock.
    always_comb begin
        mulAccNext   = mulAcc;
        mulCandNext  = mulCand;
        mulPlierNext = mulPlier;
        for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
            if (mulPlierNext[0]) begin
                mulAccNext = mulAccNext + mulCandNext;
            end
            mulCandNext  = mulCandNext << 1;
            mulPlierNext = mulPlierNext >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept && isLegal && isMult) nextState = MUL;
            MUL:     if (stepCnt == 6'd1) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regWrite  <= 1'b0;
            illegal   <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            hiReg     <= '0;
            loReg     <= '0;
            mulAcc    <= '0;
            mulCand   <= '0;
            mulPlier  <= '0;
            stepCnt   <= '0;
        end else begin
            regWrite <= 1'b0;
            illegal  <= 1'b0;
            if (accept) begin
                if (!isLegal) begin
                    illegal <= 1'b1;
                end else if (isMult) begin
                    mulAcc   <= '0;
                    mulCand  <= {32'd0, rs_data};
                    mulPlier <= rt_data;
                    stepCnt  <= MUL_STEPS;
                end else begin
                    WriteReg  <= rd;
                    WriteData <= aluResult;
                    regWrite  <= (rd != 5'd0) && !trap;
                end
            end
            if (state == MUL) begin
                mulAcc   <= mulAccNext;
                mulCand  <= mulCandNext;
                mulPlier <= mulPlierNext;
                stepCnt  <= stepCnt - 6'd1;
                // HI/LO stay architecturally stable until the product is complete.
                if (stepCnt == 6'd1) begin
                    {hiReg, loReg} <= mulAccNext;
                end
            end
        end
    end

`ifdef EXEC_OVF_TRAP_EN
    logic ovfQ;
    assign trap = signedOvf;
    always_ff @(posedge clk) begin
        if (rst) begin
            ovfQ <= 1'b0;
        end else begin
            ovfQ <= accept && isLegal && !isMult && signedOvf;
        end
    end
    assign ovf = ovfQ;
`else
    logic unusedOvf;
    assign unusedOvf = signedOvf;
    assign trap      = 1'b0;
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_rtype_exec_unit.sv
// Bench for rtype_exec_unit: two instances (1 and 4 multiplier bits per cycle) share stimulus
// and are checked every cycle against a cycle-level behavioural model plus literal expectations.
module tb_rtype_exec_unit;

`ifdef EXEC_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] rsData = '0;
    logic [31:0] rtData = '0;

    logic        rdy   [2];
    logic        busyV [2];
    logic        weV   [2];
    logic        illV  [2];
    logic        ovfV  [2];
    logic [4:0]  wreg  [2];
    logic [31:0] wdat  [2];

    int nChecks = 0;
    int nFails  = 0;

    // Model state: cycles of MUL remaining, architectural HI/LO, and expected outputs.
    int          mBusy [2] = '{0, 0};
    logic [31:0] mHi   [2];
    logic [31:0] mLo   [2];
    logic [63:0] mProd [2];
    logic        mWe   [2];
    logic        mIll  [2];
    logic        mOvf  [2];
    logic [4:0]  mReg  [2];
    logic [31:0] mData [2];
    bit          modelLive = 1'b0;

    always #5 clk = ~clk;

    rtype_exec_unit #(.MUL_BITS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .inst(inst), .rs_data(rsData), .rt_data(rtData),
        .regWrite(weV[0]), .WriteReg(wreg[0]), .WriteData(wdat[0]),
        .busy(busyV[0]), .illegal(illV[0]), .ovf(ovfV[0])
    );

    rtype_exec_unit #(.MUL_BITS_PER_CYCLE(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .inst(inst), .rs_data(rsData), .rt_data(rtData),
        .regWrite(weV[1]), .WriteReg(wreg[1]), .WriteData(wdat[1]),
        .busy(busyV[1]), .illegal(illV[1]), .ovf(ovfV[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rinst(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    // Behavioural model, advanced on each rising edge from the inputs present at that edge.
    initial forever begin
        logic [31:0] a, b, res;
        logic [5:0]  fn;
        logic [4:0]  sh, rd;
        logic        legal, trapHit;
        longint      wide;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            mWe[k]  = 1'b0;
            mIll[k] = 1'b0;
            mOvf[k] = 1'b0;
            if (rst) begin
                mBusy[k] = 0;
                mHi[k]   = '0;
                mLo[k]   = '0;
                mReg[k]  = '0;
                mData[k] = '0;
                modelLive = 1'b1;
            end else if (mBusy[k] != 0) begin
                mBusy[k]--;
                if (mBusy[k] == 0) {mHi[k], mLo[k]} = mProd[k];
            end else if (in_valid) begin
                a = rsData; b = rtData;
                fn = inst[5:0]; sh = inst[10:6]; rd = inst[15:11];
                legal = (inst[31:26] == 6'd0);
                res = '0; wide = 0; trapHit = 1'b0;
                case (fn)
                    6'h20: begin
                        res = a + b;
                        wide = longint'($signed(a)) + longint'($signed(b));
                        trapHit = (wide != longint'($signed(res)));
                    end
                    6'h21: res = a + b;
                    6'h22: begin
                        res = a - b;
                        wide = longint'($signed(a)) - longint'($signed(b));
                        trapHit = (wide != longint'($signed(res)));
                    end
                    6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    6'h00: res = b << sh;
                    6'h02: res = b >> sh;
                    6'h03: res = $signed(b) >>> sh;
                    6'h10: res = mHi[k];
                    6'h12: res = mLo[k];
                    6'h19: res = '0;
                    default: legal = 1'b0;
                endcase
                if (!legal) begin
                    mIll[k] = 1'b1;
                end else if (fn == 6'h19) begin
                    mProd[k] = {32'd0, a} * {32'd0, b};
                    mBusy[k] = 32 / ((k == 0) ? 1 : 4);
                end else begin
                    mReg[k]  = rd;
                    mData[k] = res;
                    if (TRAP && trapHit) mOvf[k] = 1'b1;
                    else mWe[k] = (rd != 5'd0);
                end
            end
        end
    end

    // Every-cycle comparison, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (modelLive) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("in_ready[%0d]", k), 32'(rdy[k]),   32'(mBusy[k] == 0));
                chk($sformatf("busy[%0d]", k),     32'(busyV[k]), 32'(mBusy[k] != 0));
                chk($sformatf("regWrite[%0d]", k), 32'(weV[k]),   32'(mWe[k]));
                chk($sformatf("illegal[%0d]", k),  32'(illV[k]),  32'(mIll[k]));
                chk($sformatf("ovf[%0d]", k),      32'(ovfV[k]),  32'(mOvf[k]));
                if (mWe[k]) begin
                    chk($sformatf("WriteReg[%0d]", k),  32'(wreg[k]), 32'(mReg[k]));
                    chk($sformatf("WriteData[%0d]", k), wdat[k],      mData[k]);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while ((mBusy[0] != 0 || mBusy[1] != 0) && guard < 100) begin
            in_valid = 1'b0;
            @(posedge clk); #2;
            guard++;
        end
        if (guard >= 100) begin
            nChecks++;
            nFails++;
            $display("FAIL issue_wait: got still busy after %0d cycles, expected idle", guard);
        end
        inst = i; rsData = a; rtData = b; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #2;
    endtask

    initial begin
        int cnt0, cnt1;
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ready[%0d]", k), 32'(rdy[k]),   32'd1);
            chk($sformatf("rst_busy[%0d]", k),  32'(busyV[k]), 32'd0);
            chk($sformatf("rst_we[%0d]", k),    32'(weV[k]),   32'd0);
            chk($sformatf("rst_reg[%0d]", k),   32'(wreg[k]),  32'd0);
            chk($sformatf("rst_data[%0d]", k),  wdat[k],       32'd0);
        end
        rst = 1'b0;

        issue(32'h00430820, 32'd7, 32'd8);
        chk("add_we",   32'(weV[0]),  32'd1);
        chk("add_reg",  32'(wreg[0]), 32'd1);
        chk("add_data", wdat[0],      32'h0000000F);
        idle();
        chk("add_we_drop", 32'(weV[0]), 32'd0);

        issue(rinst(5'd2, 5'd3, 5'd4, 5'd0, 6'h2A), 32'hFFFFFFFF, 32'd1);
        chk("slt_data", wdat[0], 32'd1);
        issue(rinst(5'd2, 5'd3, 5'd5, 5'd0, 6'h2B), 32'hFFFFFFFF, 32'd1);
        chk("sltu_we",   32'(weV[0]), 32'd1);
        chk("sltu_data", wdat[0],     32'd0);
        issue(rinst(5'd0, 5'd3, 5'd6, 5'd4, 6'h03), 32'd0, 32'h80000000);
        chk("sra_data", wdat[0], 32'hF8000000);

        issue(rinst(5'd1, 5'd2, 5'd9,  5'd0, 6'h22), 32'd5, 32'd9);
        issue(rinst(5'd1, 5'd2, 5'd10, 5'd0, 6'h23), 32'd0, 32'd1);
        issue(rinst(5'd1, 5'd2, 5'd11, 5'd0, 6'h24), 32'hF0F0_1234, 32'h0FF0_FF00);
        issue(rinst(5'd1, 5'd2, 5'd12, 5'd0, 6'h25), 32'hF0F0_1234, 32'h0FF0_FF00);
        issue(rinst(5'd1, 5'd2, 5'd13, 5'd0, 6'h26), 32'hF0F0_1234, 32'h0FF0_FF00);
        issue(rinst(5'd1, 5'd2, 5'd14, 5'd0, 6'h27), 32'd0, 32'd0);
        chk("nor_data", wdat[0], 32'hFFFFFFFF);
        issue(rinst(5'd1, 5'd2, 5'd15, 5'd31, 6'h00), 32'd0, 32'd3);
        issue(rinst(5'd1, 5'd2, 5'd16, 5'd8, 6'h02), 32'd0, 32'h8000_0000);
        issue(rinst(5'd1, 5'd2, 5'd17, 5'd0, 6'h22), 32'h8000_0000, 32'd1);
        idle();

        issue(rinst(5'd1, 5'd2, 5'd0, 5'd0, 6'h19), 32'hFFFFFFFF, 32'd2);
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 40; i++) begin
            cnt0 += int'(busyV[0]);
            cnt1 += int'(busyV[1]);
            @(posedge clk); #2;
        end
        chk("mul1_busy_cycles", 32'(cnt0), 32'd32);
        chk("mul4_busy_cycles", 32'(cnt1), 32'd8);
        issue(rinst(5'd0, 5'd0, 5'd7, 5'd0, 6'h10), 32'd0, 32'd0);
        chk("mfhi_data0", wdat[0], 32'd1);
        chk("mfhi_data1", wdat[1], 32'd1);
        issue(rinst(5'd0, 5'd0, 5'd8, 5'd0, 6'h12), 32'd0, 32'd0);
        chk("mflo_data0", wdat[0], 32'hFFFFFFFE);
        chk("mflo_data1", wdat[1], 32'hFFFFFFFE);

        issue(rinst(5'd1, 5'd2, 5'd9, 5'd0, 6'h29), 32'd1, 32'd2);
        chk("illegal_pulse", 32'(illV[0]), 32'd1);
        chk("illegal_we",    32'(weV[0]),  32'd0);
        idle();
        chk("illegal_drop", 32'(illV[0]), 32'd0);
        issue({6'h08, 5'd1, 5'd2, 5'd9, 5'd0, 6'h20}, 32'd1, 32'd2);
        chk("illegal_op", 32'(illV[0]), 32'd1);
        issue(rinst(5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 32'd3, 32'd4);
        chk("rd0_we",  32'(weV[0]),  32'd0);
        chk("rd0_ill", 32'(illV[0]), 32'd0);

        issue(rinst(5'd1, 5'd2, 5'd10, 5'd0, 6'h20), 32'h7FFFFFFF, 32'd1);
`ifdef EXEC_OVF_TRAP_EN
        chk("ovf_add_we",  32'(weV[0]),  32'd0);
        chk("ovf_add_ovf", 32'(ovfV[0]), 32'd1);
`else
        chk("ovf_add_data", wdat[0],      32'h80000000);
        chk("ovf_add_ovf",  32'(ovfV[0]), 32'd0);
`endif
        issue(rinst(5'd1, 5'd2, 5'd11, 5'd0, 6'h21), 32'h7FFFFFFF, 32'd1);
        chk("addu_we",   32'(weV[0]), 32'd1);
        chk("addu_data", wdat[0],     32'h80000000);
        idle();

        issue(rinst(5'd1, 5'd2, 5'd0, 5'd0, 6'h19), 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("mulrst_ready", 32'(rdy[0]),   32'd1);
        chk("mulrst_busy",  32'(busyV[0]), 32'd0);
        issue(rinst(5'd0, 5'd0, 5'd12, 5'd0, 6'h10), 32'd0, 32'd0);
        chk("mulrst_mfhi_we",   32'(weV[0]), 32'd1);
        chk("mulrst_mfhi_data", wdat[0],     32'd0);
        issue(rinst(5'd0, 5'd0, 5'd13, 5'd0, 6'h12), 32'd0, 32'd0);
        chk("mulrst_mflo_data1", wdat[1], 32'd0);

        repeat (3) idle();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
        $fatal(1, "bench timed out");
    end

endmodule
